if_rd_arbiter: RTL and testbench
================================

# if_rd_arbiter

Round-robin scheduler that shares the chip's single SPI read interface (async-FIFO read side) among up to NUM_REQ on-chip consumers: configuration, activations, activation flags, weights and weight flags. It picks one pending requester, issues a one-cycle `config_paulse` with that requester's 4-bit code and schedule word, then throttles `rd_req` by the requester's buffer-ready. It steers returned `rd_valid`/`rd_data` to the winner until `rd_done`, and releases the interface once it reports `config_ready` again. It sits between the datapath buffer loaders and the read-interface top.

## Interface
- NUM_REQ, 5, number of requesters; requester i is sent code i on `config_data` (0 CFG, 1 ACT, 2 FLGACT, 3 WEI, 4 FLGWEI); max 16
- SPI_WIDTH, 32, data word width
- SCHED_WIDTH, 8, schedule word width
- CNT_WIDTH, 20, per-transfer word counter width

- clk_chip  in  1  chip clock; the only clock
- reset_n_chip  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request per requester, held until its `xfer_done`
- req_schedule  in  NUM_REQ*SCHED_WIDTH  schedule word of requester i at bits [i*SCHED_WIDTH +: SCHED_WIDTH]
- rdy  in  NUM_REQ  requester i can accept a word this cycle
- config_ready  in  1  read interface idle
- config_paulse  out  1  one-cycle transfer start
- config_data  out  4  code of granted requester
- IF_schedule  out  SCHED_WIDTH  schedule word of granted requester
- rd_req  out  1  pop request to the read interface
- rd_valid  in  1  data word valid
- rd_data  in  SPI_WIDTH  data word
- rd_done  in  1  one-cycle end-of-transfer pulse
- grant  out  NUM_REQ  one-hot owner, registered
- out_valid  out  NUM_REQ  per-requester data strobe
- out_data  out  SPI_WIDTH  shared data bus (= `rd_data`)
- xfer_done  out  NUM_REQ  one-cycle completion pulse to the owner
- xfer_words  out  CNT_WIDTH  words delivered in the last completed transfer
- busy  out  1  state != IDLE
- err_stray  out  1  sticky: `rd_valid` seen outside XFER

## Operation
- States: IDLE, CFG, XFER, DONE.
- IDLE: when `config_ready`=1 and |`req`, select the first set bit of `req` searching from ptr+1 upward with wrap. Register `grant`, `config_data`=index, and `IF_schedule`=slice. Set ptr=index and go to CFG. If `config_ready`=0, wait.
- CFG: `config_paulse`=1 for exactly this cycle. Go to XFER.
- XFER:
  - `rd_req` = `rdy`[g] & ~`rd_done`.
  - `out_valid`[g] = `rd_valid`; all other bits are 0.
  - The word counter increments on each `rd_valid`.
  - On `rd_done`: pulse `xfer_done`[g], load `xfer_words` with the final count (including any `rd_valid` in the same cycle), clear `grant`, and go to DONE.
- DONE: wait for `config_ready`=1, then go to IDLE. No new grant is issued in the same cycle.
- `req` deasserted mid-transfer is ignored; the transfer runs to `rd_done`. Requests that drop before grant are never served.
- `rd_valid` in IDLE, CFG or DONE: data is dropped and `err_stray` sets. Only reset clears `err_stray`.
- Reset values: state IDLE; ptr = NUM_REQ-1, so requester 0 wins first. Every output resets to 0, including the `config_data`/`IF_schedule` registers, the word counter and `xfer_words`.
- Asynchronous reset mid-transfer returns to IDLE immediately with all outputs 0. Counter width wraps modulo 2^CNT_WIDTH.

## Timing
- `config_paulse` asserts 1 cycle after `req` is sampled in IDLE with `config_ready`=1. `config_data`/`IF_schedule` are stable from that cycle until the next grant.
- `rd_req` can assert the cycle after `config_paulse`. `out_valid` is combinational from `rd_valid`, so there is zero latency.
- `xfer_done` is registered and asserts 1 cycle after `rd_done`.
- Minimum back-to-back grant spacing: the cycle after `config_ready` returns high.
- `rd_done` and `rd_valid` in the same cycle: the word is delivered and counted.

## Test plan
- Single request: `req`=5'b00100, `rdy`=1, interface returns 8 words then `rd_done` -> `config_data`=2, one `config_paulse`, `out_valid`[2] pulses 8 times, `xfer_done`[2] pulses once, `xfer_words`=8.
- Round robin: `req`=5'b11111 held for five transfers -> grant order 0,1,2,3,4, then 0 again; each transfer preceded by exactly one `config_paulse`.
- Back-pressure: `rdy`[3] toggles every 2 cycles during a WEI transfer -> `rd_req` follows `rdy`[3]; no `out_valid` to other requesters.
- Wait on busy interface: `config_ready`=0 with `req`=5'b00001 -> no `config_paulse` until `config_ready` rises, then the paulse follows 1 cycle later.
- Stray data: `rd_valid`=1 in IDLE -> `err_stray`=1 and all `out_valid` bits 0. Reset mid-XFER -> `grant`=0, `rd_req`=0, `busy`=0, and after release requester 0 has priority.

Source files
------------

// File: rtl/if_rd_arbiter.sv
// rtl/if_rd_arbiter.sv - round-robin owner of the shared SPI read interface
//
// Ports:
//   clk_chip, reset_n_chip      clock, asynchronous active-low reset
//   req, req_schedule, rdy      per-requester request, schedule word, ready
//   config_ready/paulse/data    handshake that starts a transfer on the interface
//   IF_schedule                 schedule word of the granted requester
//   rd_req, rd_valid, rd_data   pop request and returned data words
//   rd_done                     end-of-transfer pulse from the interface
//   grant, out_valid, out_data  owner one-hot and data steered to it
//   xfer_done, xfer_words       completion pulse and delivered word count
//   busy, err_stray             not idle; sticky data-outside-transfer flag
module if_rd_arbiter #(
  parameter int NUM_REQ     = 5,
  parameter int SPI_WIDTH   = 32,
  parameter int SCHED_WIDTH = 8,
  parameter int CNT_WIDTH   = 20
) (
  input  logic                           clk_chip,
  input  logic                           reset_n_chip,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*SCHED_WIDTH-1:0] req_schedule,
  input  logic [NUM_REQ-1:0]             rdy,
  input  logic                           config_ready,
  output logic                           config_paulse,
  output logic [3:0]                     config_data,
  output logic [SCHED_WIDTH-1:0]         IF_schedule,
  output logic                           rd_req,
  input  logic                           rd_valid,
  input  logic [SPI_WIDTH-1:0]           rd_data,
  input  logic                           rd_done,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             out_valid,
  output logic [SPI_WIDTH-1:0]           out_data,
  output logic [NUM_REQ-1:0]             xfer_done,
  output logic [CNT_WIDTH-1:0]           xfer_words,
  output logic                           busy,
  output logic                           err_stray
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_XFER, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [3:0]             cfg_q, cfg_d;
  logic [SCHED_WIDTH-1:0] sched_q, sched_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   words_q, words_d;
  logic [NUM_REQ-1:0]     xfer_done_q, xfer_done_d;
  logic                   err_q, err_d;

  logic [SCHED_WIDTH-1:0] sched_arr [NUM_REQ];
  logic                   found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       cand_idx;
  int                     cand;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sched
    assign sched_arr[i] = req_schedule[i*SCHED_WIDTH +: SCHED_WIDTH];
  end

  // First pending requester after the last winner, wrapping around.
  always_comb begin
    found    = 1'b0;
    win_idx  = ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_W'(NUM_REQ - 1);
      grant_q     <= '0;
      cfg_q       <= '0;
      sched_q     <= '0;
      cnt_q       <= '0;
      words_q     <= '0;
      xfer_done_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cfg_q       <= cfg_d;
      sched_q     <= sched_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      xfer_done_q <= xfer_done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cfg_d       = cfg_q;
    sched_d     = sched_q;
    cnt_d       = cnt_q;
    words_d     = words_q;
    xfer_done_d = '0;
    // Data arriving while no transfer is open has nowhere to go.
    err_d       = err_q | (rd_valid & (state_q != S_XFER));
    case (state_q)
      S_IDLE: begin
        if (config_ready && found) begin
          state_d = S_CFG;
          ptr_d   = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          cfg_d   = 4'(win_idx);
          sched_d = sched_arr[win_idx];
          cnt_d   = '0;
        end
      end
      S_CFG:  state_d = S_XFER;
      S_XFER: begin
        if (rd_valid) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (rd_done) begin
          // cnt_d already includes a word delivered alongside rd_done.
          xfer_done_d = grant_q;
          words_d     = cnt_d;
          grant_d     = '0;
          state_d     = S_DONE;
        end
      end
      S_DONE: if (config_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    config_paulse = (state_q == S_CFG);
    rd_req        = 1'b0;
    out_valid     = '0;
    if (state_q == S_XFER) begin
      rd_req    = (|(rdy & grant_q)) & ~rd_done;
      out_valid = rd_valid ? grant_q : '0;
    end
  end

  assign grant       = grant_q;
  assign config_data = cfg_q;
  assign IF_schedule = sched_q;
  assign xfer_done   = xfer_done_q;
  assign xfer_words  = words_q;
  assign err_stray   = err_q;
  assign out_data    = rd_data;

endmodule

// File: tb/tb_if_rd_arbiter.sv
// tb/tb_if_rd_arbiter.sv - randomized self-checking bench for if_rd_arbiter
module tb_if_rd_arbiter;
  localparam int N   = 5;
  localparam int SW  = 32;
  localparam int SCW = 8;
  localparam int CW  = 20;

  logic              clk_chip = 1'b0;
  logic              reset_n_chip = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*SCW-1:0]  req_schedule = '0;
  logic [N-1:0]      rdy = '0;
  logic              config_ready = 1'b0;
  logic              config_paulse;
  logic [3:0]        config_data;
  logic [SCW-1:0]    IF_schedule;
  logic              rd_req;
  logic              rd_valid = 1'b0;
  logic [SW-1:0]     rd_data = '0;
  logic              rd_done = 1'b0;
  logic [N-1:0]      grant;
  logic [N-1:0]      out_valid;
  logic [SW-1:0]     out_data;
  logic [N-1:0]      xfer_done;
  logic [CW-1:0]     xfer_words;
  logic              busy;
  logic              err_stray;

  int   total = 0;
  int   bad = 0;
  int   last_srv = N - 1;
  logic exp_err = 1'b0;

  if_rd_arbiter #(.NUM_REQ(N), .SPI_WIDTH(SW), .SCHED_WIDTH(SCW), .CNT_WIDTH(CW)) dut (
    .clk_chip(clk_chip), .reset_n_chip(reset_n_chip), .req(req), .req_schedule(req_schedule),
    .rdy(rdy), .config_ready(config_ready), .config_paulse(config_paulse),
    .config_data(config_data), .IF_schedule(IF_schedule), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .xfer_done(xfer_done),
    .xfer_words(xfer_words), .busy(busy), .err_stray(err_stray)
  );

  always #5 clk_chip = ~clk_chip;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_chip);
    #1;
  endtask

  // Reference rule: next owner is the first requester after the last one served.
  function automatic int pick(input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) begin
      if (r[(last_srv + i) % N]) return (last_srv + i) % N;
    end
    return -1;
  endfunction

  // One complete transfer; starts and ends at posedge+1 with the DUT idle.
  task automatic run_xfer(input logic [N-1:0] r, input int nwords, input int rdy_mode,
                          input int pre_wait);
    int w, k, cyc, d;
    logic [N-1:0] oh;
    logic [SCW-1:0] exp_sched;
    logic [63:0] tmp;
    bit fin;
    w = pick(r);
    last_srv = w;
    oh = '0;
    oh[w] = 1'b1;
    tmp = {$urandom(), $urandom()};
    req_schedule = tmp[N*SCW-1:0];
    exp_sched = SCW'(req_schedule >> (w * SCW));
    req = r;
    config_ready = 1'b0;
    for (int j = 0; j < pre_wait; j++) begin
      #4;
      total++; if (config_paulse !== 1'b0) begin bad++; $display("FAIL wait_paulse: got %b want 0", config_paulse); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wait_busy: got %b want 0", busy); end
      tick();
    end
    config_ready = 1'b1;
    #4;
    total++; if (config_paulse !== 1'b0) begin bad++; $display("FAIL idle_paulse: got %b want 0", config_paulse); end
    total++; if (grant !== '0) begin bad++; $display("FAIL idle_grant: got %b want 0", grant); end
    tick();
    config_ready = 1'b0;
    #4;
    total++; if (config_paulse !== 1'b1) begin bad++; $display("FAIL cfg_paulse: got %b want 1", config_paulse); end
    total++; if (config_data !== 4'(w)) begin bad++; $display("FAIL cfg_data: got %0d want %0d", config_data, w); end
    total++; if (IF_schedule !== exp_sched) begin bad++; $display("FAIL cfg_sched: got %h want %h", IF_schedule, exp_sched); end
    total++; if (grant !== oh) begin bad++; $display("FAIL cfg_grant: got %b want %b", grant, oh); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL cfg_rd_req: got %b want 0", rd_req); end
    tick();
    k = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      rdy = N'($urandom());
      if (rdy_mode == 0) rdy = '1;
      if (rdy_mode == 2) rdy[w] = ((cyc / 2) % 2 == 0);
      rd_valid = (k < nwords) && (($urandom_range(0, 3) != 0) || cyc > 200);
      rd_data = $urandom();
      if (k == nwords) rd_done = 1'b1;
      else if (rd_valid && k + 1 == nwords) rd_done = ($urandom_range(0, 1) == 1);
      else rd_done = 1'b0;
      #4;
      total++; if (rd_req !== (rdy[w] & ~rd_done)) begin bad++; $display("FAIL xfer_rd_req: got %b want %b", rd_req, rdy[w] & ~rd_done); end
      total++; if (out_valid !== (rd_valid ? oh : '0)) begin bad++; $display("FAIL xfer_out_valid: got %b want %b", out_valid, rd_valid ? oh : '0); end
      total++; if (out_data !== rd_data) begin bad++; $display("FAIL xfer_out_data: got %h want %h", out_data, rd_data); end
      total++; if (config_paulse !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL xfer_ctl: got paulse=%b busy=%b want 0/1", config_paulse, busy); end
      if (rd_valid) k++;
      fin = rd_done;
      cyc++;
      tick();
    end
    rd_done = 1'b0;
    rd_valid = 1'b0;
    d = $urandom_range(0, 2);
    for (int j = 0; j <= d; j++) begin
      config_ready = (j == d);
      if (j == d) req = '0;
      #4;
      if (j == 0) begin
        total++; if (xfer_done !== oh) begin bad++; $display("FAIL done_pulse: got %b want %b", xfer_done, oh); end
        total++; if (xfer_words !== CW'(k)) begin bad++; $display("FAIL done_words: got %0d want %0d", xfer_words, k); end
        total++; if (grant !== '0) begin bad++; $display("FAIL done_grant: got %b want 0", grant); end
      end
      total++; if (busy !== 1'b1 || rd_req !== 1'b0) begin bad++; $display("FAIL done_state: got busy=%b rd_req=%b want 1/0", busy, rd_req); end
      tick();
    end
    #4;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL end_busy: got %b want 0", busy); end
    total++; if (xfer_done !== '0) begin bad++; $display("FAIL end_done: got %b want 0", xfer_done); end
    total++; if (config_data !== 4'(w)) begin bad++; $display("FAIL end_cfg_stable: got %0d want %0d", config_data, w); end
    total++; if (err_stray !== exp_err) begin bad++; $display("FAIL end_err: got %b want %b", err_stray, exp_err); end
    tick();
  endtask

  task automatic test_reset();
    @(posedge clk_chip);
    #1;
    total++; if ({grant, out_valid, xfer_done} !== '0) begin bad++; $display("FAIL rst_vecs: got %b want 0", {grant, out_valid, xfer_done}); end
    total++; if ({config_data, IF_schedule} !== '0) begin bad++; $display("FAIL rst_cfg: got %h want 0", {config_data, IF_schedule}); end
    total++; if (xfer_words !== '0) begin bad++; $display("FAIL rst_words: got %0d want 0", xfer_words); end
    total++; if ({config_paulse, rd_req, busy, err_stray} !== 4'b0) begin bad++; $display("FAIL rst_bits: got %b want 0", {config_paulse, rd_req, busy, err_stray}); end
    reset_n_chip = 1'b1;
    #4;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy: got %b want 0", busy); end
    tick();
  endtask

  task automatic test_round_robin();
    for (int t = 0; t < 6; t++) begin
      total++; if (pick(5'b11111) != (t % N)) begin bad++; $display("FAIL rr_model_order: got %0d want %0d", pick(5'b11111), t % N); end
      run_xfer(5'b11111, 2 + t, 0, 0);
    end
  endtask

  task automatic test_single();
    run_xfer(5'b00100, 8, 0, 0);
  endtask

  task automatic test_backpressure();
    run_xfer(5'b01000, 10, 2, 0);
  endtask

  task automatic test_wait_busy();
    run_xfer(5'b00001, 3, 0, 4);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      run_xfer(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 12), 1, $urandom_range(0, 2));
    end
  endtask

  task automatic test_stray();
    rd_valid = 1'b1;
    rd_data = $urandom();
    #4;
    total++; if (out_valid !== '0) begin bad++; $display("FAIL stray_out_valid: got %b want 0", out_valid); end
    total++; if (err_stray !== 1'b0) begin bad++; $display("FAIL stray_pre: got %b want 0", err_stray); end
    tick();
    rd_valid = 1'b0;
    exp_err = 1'b1;
    #4;
    total++; if (err_stray !== 1'b1) begin bad++; $display("FAIL stray_set: got %b want 1", err_stray); end
    tick();
    #4;
    total++; if (err_stray !== 1'b1) begin bad++; $display("FAIL stray_sticky: got %b want 1", err_stray); end
    tick();
  endtask

  task automatic test_reset_mid();
    req = 5'b01000;
    config_ready = 1'b1;
    tick();
    config_ready = 1'b0;
    tick();
    rdy = '1;
    rd_valid = 1'b1;
    tick();
    #1;
    total++; if (busy !== 1'b1 || rd_req !== 1'b1) begin bad++; $display("FAIL mid_in_xfer: got busy=%b rd_req=%b want 1/1", busy, rd_req); end
    #1;
    reset_n_chip = 1'b0;
    #1;
    exp_err = 1'b0;
    total++; if (grant !== '0) begin bad++; $display("FAIL mid_rst_grant: got %b want 0", grant); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL mid_rst_rd_req: got %b want 0", rd_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (out_valid !== '0) begin bad++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
    total++; if (err_stray !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %b want 0", err_stray); end
    total++; if (config_data !== 4'd0) begin bad++; $display("FAIL mid_rst_cfg: got %0d want 0", config_data); end
    rd_valid = 1'b0;
    req = '0;
    last_srv = N - 1;
    tick();
    reset_n_chip = 1'b1;
    tick();
    run_xfer(5'b11111, 3, 1, 0);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_wait_busy();
    test_random();
    test_stray();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
